sequence_lock: RTL
==================

SEQUENCE_LOCK -- requirements
Module: sequence_lock

Interface
REQ-001 SHALL have parameter CODE_RESET, default 16'h1234, meaning combination loaded at reset; digit 0 is in [15:12] and digit 3 is in [3:0].
REQ-002 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive wrong entries that triggers the alarm; legal range is 1-7.
REQ-003 SHALL have parameter OPEN_CYCLES, default 1000, meaning the inactivity timeout in OPEN, in clk cycles.
REQ-004 SHALL have parameter ALARM_CYCLES, default 2000, meaning the alarm duration in clk cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port key, input, 5 bits: encoded key from the upstream key synchroniser; 0-15 = hex digit, 16 = ENTER, 17-31 = invalid.
REQ-008 SHALL have port strobe, input, 1 bit: one-cycle pulse marking key valid for that cycle.
REQ-009 SHALL have port unlock, output, 1 bit: high while in OPEN.
REQ-010 SHALL have port alarm, output, 1 bit: high while in ALARM.
REQ-011 SHALL have port digit_cnt, output, 3 bits: digits accepted in the current entry, saturating at 4.
REQ-012 SHALL have port fail_cnt, output, 3 bits: consecutive wrong entries.

Function
REQ-013 SHALL implement states LOCKED, OPEN and ALARM; all outputs SHALL be registered, changing on the clk edge after the causing strobe.
REQ-014 SHALL ignore key whenever strobe=0, and SHALL ignore any strobe with key 17-31 in every state.
REQ-015 In LOCKED or OPEN, a digit strobe with digit_cnt<4 SHALL shift the digit into a 16-bit entry register (new digit into [3:0]) and increment digit_cnt.
REQ-016 A digit strobe with digit_cnt=4 SHALL leave entry unchanged and set a sticky overflow flag for the current entry.
REQ-017 ENTER in LOCKED with digit_cnt=4, overflow=0 and entry=combination SHALL go to OPEN, clear fail_cnt, and load the open timer.
REQ-018 Any other ENTER in LOCKED SHALL increment fail_cnt; when fail_cnt reaches MAX_FAIL it SHALL go to ALARM and load the alarm timer, otherwise it SHALL stay in LOCKED.
REQ-019 Every ENTER SHALL clear entry, digit_cnt and overflow in the same edge, in every state.
REQ-020 In OPEN, each valid strobe SHALL reload the open timer to OPEN_CYCLES; timer expiry without a strobe SHALL return to LOCKED.
REQ-021 ENTER in OPEN with digit_cnt=4 and overflow=0 SHALL write entry into the combination register and go to LOCKED.
REQ-022 Any other ENTER in OPEN SHALL go to LOCKED with the combination unchanged.
REQ-023 Leaving OPEN by timeout SHALL clear entry, digit_cnt and overflow.
REQ-024 In ALARM, all strobes SHALL be ignored and digit_cnt SHALL be held at 0.
REQ-025 After ALARM_CYCLES in ALARM, the block SHALL go to LOCKED and clear fail_cnt.
REQ-026 When timer expiry and a strobe coincide in OPEN, the strobe SHALL win.
REQ-027 Timers SHALL be down-counters sized $clog2(max(OPEN_CYCLES,ALARM_CYCLES)+1) and SHALL not wrap.
REQ-028 fail_cnt SHALL never exceed MAX_FAIL.

Reset
REQ-029 rst=0 SHALL asynchronously force LOCKED, unlock=0, alarm=0, digit_cnt=0, fail_cnt=0, entry=0, overflow=0, timers=0 and combination=CODE_RESET.
REQ-030 Reset mid-entry, in OPEN or in ALARM SHALL discard all progress, including any reprogrammed combination.
REQ-031 The first strobe SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-032 Reset, then strobes 1,2,3,4,ENTER -> unlock=1 one cycle after the ENTER strobe, fail_cnt=0, digit_cnt=0.
REQ-033 Reset, then 1,2,3,5,ENTER three times -> fail_cnt 1,2, then alarm=1; all strobes during alarm are ignored; alarm=0, state LOCKED and fail_cnt=0 after ALARM_CYCLES.
REQ-034 Strobes 1,2,3,4,5,ENTER -> overflow, so fail_cnt=1 and unlock=0; strobes 1,2,ENTER -> fail_cnt=2.
REQ-035 Open with 1234, then A,B,C,D,ENTER -> LOCKED; then 1234,ENTER -> fail; then ABCD,ENTER -> unlock=1.
REQ-036 Open, then no strobes -> unlock drops exactly OPEN_CYCLES cycles after the last strobe; a strobe on the expiry cycle keeps unlock=1.
REQ-037 Open, then digit 7, then rst=0 mid-cycle -> outputs go to 0 immediately without waiting for clk; after release, 1234,ENTER -> unlock=1.

Source files
------------

// File: rtl/sequence_lock.sv
// Four-digit hex combination lock with open timeout, failed-entry alarm
// and in-place reprogramming of the combination while open.
module sequence_lock #(
  parameter logic [15:0] CODE_RESET   = 16'h1234,
  parameter int          MAX_FAIL     = 3,
  parameter int          OPEN_CYCLES  = 1000,
  parameter int          ALARM_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key,
  input  logic       strobe,
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  localparam int TMAX = (OPEN_CYCLES > ALARM_CYCLES) ?
                        OPEN_CYCLES : ALARM_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] T_ALARM = TW'(ALARM_CYCLES);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [2:0]    F_MAX   = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    LOCKED,
    OPEN,
    ALARM
  } state_t;

  state_t        state_q, state_n;
  logic [15:0]   combo_q, combo_n;
  logic [15:0]   entry_q, entry_n;
  logic [2:0]    cnt_q, cnt_n;
  logic          ovf_q, ovf_n;
  logic [2:0]    fail_q, fail_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          unlock_n, alarm_n;

  logic       is_digit, is_enter;
  logic       full;
  logic [2:0] fail_inc;

  assign is_digit = strobe && !key[4];
  assign is_enter = strobe && (key == 5'd16);
  assign full     = (cnt_q == 3'd4);
  assign fail_inc = fail_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOCKED;
      combo_q   <= CODE_RESET;
      entry_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      fail_q    <= '0;
      timer_q   <= '0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_q   <= state_n;
      combo_q   <= combo_n;
      entry_q   <= entry_n;
      cnt_q     <= cnt_n;
      ovf_q     <= ovf_n;
      fail_q    <= fail_n;
      timer_q   <= timer_n;
      unlock    <= unlock_n;
      alarm     <= alarm_n;
    end
  end

  always_comb begin
    state_n = state_q;
    combo_n = combo_q;
    entry_n = entry_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    fail_n  = fail_q;
    timer_n = timer_q;

    // Digit accumulation is shared by LOCKED and OPEN
    if (is_digit && state_q != ALARM) begin
      if (full) begin
        ovf_n = 1'b1;
      end else begin
        entry_n = {entry_q[11:0], key[3:0]};
        cnt_n   = cnt_q + 3'd1;
      end
    end

    unique case (state_q)
      LOCKED: begin
        if (is_enter) begin
          entry_n = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          if (full && !ovf_q && entry_q == combo_q) begin
            state_n = OPEN;
            fail_n  = '0;
            timer_n = T_OPEN;
          end else if (fail_inc >= F_MAX) begin
            state_n = ALARM;
            fail_n  = F_MAX;
            timer_n = T_ALARM;
          end else begin
            fail_n  = fail_inc;
          end
        end
      end
      OPEN: begin
        if (is_digit || is_enter) begin
          timer_n = T_OPEN;
          if (is_enter) begin
            entry_n = '0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
            state_n = LOCKED;
            timer_n = '0;
            if (full && !ovf_q)
              combo_n = entry_q;
          end
        end else if (timer_q <= T_ONE) begin
          state_n = LOCKED;
          entry_n = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          timer_n = '0;
        end else begin
          timer_n = timer_q - T_ONE;
        end
      end
      ALARM: begin
        cnt_n = '0;
        if (timer_q <= T_ONE) begin
          state_n = LOCKED;
          fail_n  = '0;
          timer_n = '0;
        end else begin
          timer_n = timer_q - T_ONE;
        end
      end
      default: state_n = LOCKED;
    endcase

    unlock_n = (state_n == OPEN);
    alarm_n  = (state_n == ALARM);
  end

  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule
